// File: rtl/fifo_pkg.sv
// Shared constants and sizing helpers for the synchronous FIFO family.
package fifo_pkg;

    localparam int RD_MODE_REG  = 0;
    localparam int RD_MODE_FWFT = 1;

    // Address width never collapses to zero, even for a 2-entry FIFO.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Storage array: one synchronous write port, one combinational read port, no reset.
module sync_fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [clog2_min1(DEPTH)-1:0]   waddr,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [clog2_min1(DEPTH)-1:0]   raddr,
    output logic [DATA_WIDTH-1:0]          rdata_comb
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata_comb = mem[raddr];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: pointers, occupancy, threshold flags, sticky
// error flags and either registered or first-word-fall-through read output.
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int FWFT       = RD_MODE_REG,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    wr_en,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    rd_en,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int ADDR_W = clog2_min1(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "sync_fifo_ctrl: DEPTH must be a power of two >= 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $fatal(1, "sync_fifo_ctrl: AF_THRESH out of range 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $fatal(1, "sync_fifo_ctrl: AE_THRESH out of range 0..DEPTH-1");
    end

    logic [ADDR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      cnt_q;
    logic                  rd_acc, wr_acc;
    logic [DATA_WIDTH-1:0] rdata_comb;

    assign full         = (cnt_q == CNT_W'(DEPTH));
    assign empty        = (cnt_q == '0);
    assign almost_full  = (cnt_q >= CNT_W'(AF_THRESH));
    assign almost_empty = (cnt_q <= CNT_W'(AE_THRESH));
    assign count        = cnt_q;

    // A full FIFO still takes a write when the same cycle pops a word.
    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_en & (~full | rd_acc);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt_q     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt_q     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (rd_acc) rd_ptr <= rd_ptr + ADDR_W'(1);
            if (wr_acc & ~rd_acc)      cnt_q <= cnt_q + CNT_W'(1);
            else if (rd_acc & ~wr_acc) cnt_q <= cnt_q - CNT_W'(1);
            if (wr_en & ~wr_acc) overflow  <= 1'b1;
            if (rd_en & ~rd_acc) underflow <= 1'b1;
        end
    end

    sync_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk        (clk),
        .we         (wr_acc & ~flush),
        .waddr      (wr_ptr),
        .wdata      (wr_data),
        .raddr      (rd_ptr),
        .rdata_comb (rdata_comb)
    );

    if (FWFT == RD_MODE_FWFT) begin : g_fwft
        assign rd_data  = rdata_comb;
        assign rd_valid = ~empty;
    end else begin : g_reg
        logic [DATA_WIDTH-1:0] rd_data_q;
        logic                  rd_valid_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else if (flush) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_acc;
                if (rd_acc) rd_data_q <= rdata_comb;
            end
        end

        assign rd_data  = rd_data_q;
        assign rd_valid = rd_valid_q;
    end

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
Parametrised single-clock FIFO and the successor to the team's basic 4-deep synchronous FIFO. It adds a selectable read mode (registered or first-word-fall-through), programmable almost-full and almost-empty thresholds, an exposed occupancy count, a synchronous flush, sticky overflow and underflow error flags, and write-through-when-full. It is used as the standard buffering primitive between same-clock producer and consumer stages.

Parameters:
DATA_WIDTH, 8, word width in bits (≥1).
DEPTH, 16, number of entries; power of two, ≥2.
FWFT, 0, 0 = registered read (data one cycle after rd_en); 1 = first-word-fall-through.
AF_THRESH, DEPTH-2, almost_full asserted when count ≥ AF_THRESH; legal range 1..DEPTH.
AE_THRESH, 2, almost_empty asserted when count ≤ AE_THRESH; legal range 0..DEPTH-1.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
flush  in  1  synchronous clear; takes priority over wr_en and rd_en.
wr_en  in  1  write request.
wr_data  in  DATA_WIDTH  write data.
rd_en  in  1  read (pop) request.
rd_data  out  DATA_WIDTH  read data.
rd_valid  out  1  rd_data holds a valid popped or head word.
full  out  1  count == DEPTH.
empty  out  1  count == 0.
almost_full  out  1  count ≥ AF_THRESH.
almost_empty  out  1  count ≤ AE_THRESH.
count  out  $clog2(DEPTH)+1  current occupancy.
overflow  out  1  sticky: a write was rejected.
underflow  out  1  sticky: a read was rejected.

Behaviour:
- Clock is clk. Reset is reset: asynchronous, active-high.
- On reset: wr_ptr, rd_ptr and count are 0. rd_data = 0, rd_valid = 0, overflow = 0, underflow = 0. Memory contents are not reset.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- Acceptance rules:
  - rd_acc = rd_en & ~empty.
  - wr_acc = wr_en & (~full | rd_acc), so a write is allowed when full if a read is accepted in the same cycle.
  - When empty and both wr_en and rd_en are high, the write is accepted and the read is rejected.
- On an accepted write: mem[wr_ptr] <= wr_data; wr_ptr increments.
- On an accepted read: rd_ptr increments.
- Count update: +1 if wr_acc & ~rd_acc; -1 if rd_acc & ~wr_acc; otherwise unchanged. Count never exceeds DEPTH and never goes below 0.
- full, empty, almost_full and almost_empty are pure decodes of registered count, so they change in the cycle after the causing edge.
- Error flags:
  - overflow sets when wr_en & ~wr_acc.
  - underflow sets when rd_en & ~rd_acc.
  - Both hold until reset or flush.
- Read mode FWFT=0 (registered read):
  - rd_data <= mem[rd_ptr] on rd_acc; latency is 1 cycle.
  - rd_valid is registered and pulses high for exactly the cycle after each rd_acc.
  - rd_data holds its last value otherwise.
- Read mode FWFT=1 (first-word-fall-through):
  - rd_data = mem[rd_ptr] via combinational read; rd_valid = ~empty.
  - rd_en acts as an acknowledge/pop; the next word is visible in the cycle after the edge.
  - rd_data is don't-care while rd_valid = 0.
  - A word written into an empty FIFO is visible at rd_data in the cycle after the write edge.
- Flush (synchronous):
  - Pointers and count go to 0; overflow and underflow clear; rd_valid goes to 0 (FWFT=0); rd_data goes to 0.
  - wr_en and rd_en are ignored in the flush cycle, and no error flags set.
- Reset asserted mid-operation immediately forces the reset values above; contents are lost logically.
- Thresholds are checked at elaboration; an illegal AF_THRESH, AE_THRESH or non-power-of-two DEPTH is a fatal elaboration error.

Decomposition:
- Package fifo_pkg:
  - function clog2_min1(n), which returns ≥1.
  - localparam rules for ADDR_W = clog2_min1(DEPTH) and CNT_W = ADDR_W+1.
  - enum-style constants RD_MODE_REG = 0 and RD_MODE_FWFT = 1.
- One sub-module, sync_fifo_ram:
  - Parameters DATA_WIDTH and DEPTH.
  - Ports clk, we, waddr, wdata, raddr, rdata_comb: one synchronous write port and one combinational read port.
  - No reset.
- The top level holds pointers, count, flags and the read-mode output logic.

Test Plan:
- DEPTH=4, FWFT=0: write 0x11, 0x22, 0x33, 0x44 on consecutive cycles → full=1 and count=4 after the 4th edge. A 5th write of 0x55 → rejected, overflow=1, count stays 4.
- Same FIFO, rd_en held for 4 cycles → rd_data = 0x11, 0x22, 0x33, 0x44, each one cycle after its rd_en, with rd_valid pulsed each cycle. A 5th rd_en → underflow=1 and rd_data holds 0x44.
- DEPTH=4, full: wr_en=rd_en=1 with wr_data=0xAA → both accepted, count stays 4, no overflow. After draining, 0xAA is the last word out.
- FWFT=1, empty: write 0x5A → in the next cycle rd_valid=1 and rd_data=0x5A without rd_en. rd_en for one cycle → empty=1 next cycle.
- DEPTH=16, AF_THRESH=14, AE_THRESH=2: fill 0→16 → almost_empty is high through count=2 and drops at 3; almost_full rises at count=14. Drain 16→0 and check the mirror thresholds. Run 40 push/pop pairs to exercise pointer wrap with data order intact.
- Flush at count=3 with overflow=1 and wr_en=1 → next cycle count=0, empty=1, overflow=0, wr_data not stored. Assert reset mid-burst → outputs take reset values asynchronously, before the next clk edge.
